panel_scroll_ctrl: RTL and testbench
====================================

# panel_scroll_ctrl

Sequencer for the 28-bit display register of the digital panel: four 7-segment digits, 7 bits each. It holds a latched message of up to CHARS character codes and periodically parallel-loads a 4-character window of that message into the register. The window advances one character per step, left or right, with wrap-around. The block sits between the panel's control logic (start/stop/period/direction) and the register's load/s/m_sig/d inputs.

## Interface
- CHARS, 8: maximum message length in characters (≥4).
- DIV_W, 24: width of the step-period counter.
- clk  in  1: system clock, all logic on rising edge.
- clr  in  1: reset, synchronous, active-high.
- start  in  1: one-cycle pulse; begins scrolling from IDLE.
- stop  in  1: one-cycle pulse; returns to IDLE.
- dir  in  1: 0 = window advances toward higher index (text moves left); 1 = toward lower index.
- msg  in  7*CHARS: character codes; char k at msg[7k+6:7k].
- msg_len  in  $clog2(CHARS)+1: valid characters.
- period  in  DIV_W: clock cycles per step.
- reg_load  out  1: parallel-load strobe to the register.
- reg_s  out  2: register mode select; constant 2'b00 (hold).
- reg_m_sig  out  1: serial input to register; constant 0.
- reg_d  out  28: frame to load.
- busy  out  1: high while scrolling.
- wrap  out  1: one-cycle pulse when the window returns to position 0.

## Operation
- States: IDLE, LOAD, HOLD.
- IDLE: on start (and not stop), latch msg, L = clamp(msg_len, 1, CHARS) and P = max(period, 1), pos = 0, go to LOAD. If msg_len == 0, start is ignored.
- LOAD: one cycle. reg_load = 1, reg_d = frame(pos). Go to HOLD with cnt = 1. If P == 1, go directly to LOAD with pos advanced.
- HOLD: cnt increments. When cnt == P−1, advance pos and go to LOAD.
- Advance:
  - dir = 0: pos = (pos+1 == L) ? 0 : pos+1.
  - dir = 1: pos = (pos == 0) ? L−1 : pos−1.
  - dir is sampled live at the advance cycle.
- frame(pos): reg_d[27:21] = char[pos], [20:14] = char[(pos+1) mod L], [13:7] = char[(pos+2) mod L], [6:0] = char[(pos+3) mod L]. For L < 4, indices repeat modulo L.
- wrap = 1 in a LOAD cycle where pos == 0, except the first LOAD after start.
- stop in any state moves the block to IDLE on the next cycle. stop beats start when both arrive in the same cycle. start while busy is ignored.
- reg_d holds its last value in IDLE, so the display keeps the last frame. The register is never cleared by this block.
- Message, L and P are frozen while busy. Input changes take effect only at the next start.

## Timing
- Reset values: state IDLE; reg_load, wrap, busy, reg_m_sig = 0; reg_s = 2'b00; reg_d = 28'h0; pos = 0; cnt = 0.
- clr mid-scroll: all reset values appear the following cycle. No trailing reg_load.
- start sampled at edge t → reg_load high during cycle t+1 with frame(0).
- Subsequent reg_load pulses occur every P cycles exactly: t+1+kP.
- busy rises at t+1 and falls in the cycle after stop is sampled.
- All outputs are registered. reg_load and reg_d change on the same edge.

## Structure
- Shared package panel_pkg:
  - SEG_W = 7, DIGITS = 4, FRAME_W = 28.
  - Register mode constants S_HOLD = 2'b00, S_SHR = 2'b01, S_SHL = 2'b10, S_LOAD = 2'b11.
  - State enum {IDLE, LOAD, HOLD}.
- Sub-module panel_frame_mux: combinational msg, L, pos → 28-bit frame. Reused by future static-display controllers.

## Test plan
- Reset: assert clr for 2 cycles mid-HOLD → next cycle all outputs 0, busy = 0, no reg_load.
- CHARS = 8, chars 1..8, msg_len = 8, period = 3, dir = 0, start → reg_d = {1,2,3,4} at t+1, {2,3,4,5} at t+4. Frame {8,1,2,3} at pos 7, then {1,2,3,4} with wrap = 1.
- Same setup, dir = 1 → second frame {8,1,2,3}. dir toggled mid-scroll takes effect at the next advance only.
- msg_len = 2, chars {A,B}, period = 0 → reg_load every cycle (P = 1), frames alternate {A,B,A,B} / {B,A,B,A}, wrap every 2nd load.
- start and stop in the same cycle from IDLE → stays IDLE. stop in HOLD → busy drops next cycle, reg_d unchanged, no further reg_load.
- msg_len = 12 with CHARS = 8 → clamped to 8. msg_len = 0 → start ignored.

Source files
------------

// File: rtl/panel_pkg.sv
// Shared definitions for the digital panel: display geometry, shift-register
// mode encodings and the scroll sequencer state type.
package panel_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned DIGITS  = 4;
  localparam int unsigned FRAME_W = SEG_W * DIGITS;

  localparam logic [1:0] S_HOLD = 2'b00;
  localparam logic [1:0] S_SHR  = 2'b01;
  localparam logic [1:0] S_SHL  = 2'b10;
  localparam logic [1:0] S_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } state_t;

endpackage

// File: rtl/panel_frame_mux.sv
// Selects a 4-character window starting at pos from a message of len characters,
// wrapping indices modulo len; leftmost digit lands in the top bits of the frame.
module panel_frame_mux
  import panel_pkg::*;
#(
  parameter int unsigned CHARS = 8
) (
  input  logic [SEG_W*CHARS-1:0]   msg,
  input  logic [$clog2(CHARS):0]   len,
  input  logic [$clog2(CHARS)-1:0] pos,
  output logic [FRAME_W-1:0]       frame
);

  localparam int unsigned PW = $clog2(CHARS);
  localparam int unsigned IW = PW + 2;

  logic [SEG_W-1:0] chars [CHARS];
  logic [IW-1:0]    idx;

  always_comb begin
    for (int unsigned k = 0; k < CHARS; k++) begin
      chars[k] = msg[SEG_W*k +: SEG_W];
    end
  end

  // pos < len and offset <= 3, so three conditional subtractions reduce any
  // index below len even for a one-character message.
  always_comb begin
    frame = '0;
    idx   = '0;
    for (int unsigned d = 0; d < DIGITS; d++) begin
      idx = IW'(pos) + IW'(d);
      for (int unsigned k = 0; k < DIGITS - 1; k++) begin
        if (idx >= IW'(len)) idx = idx - IW'(len);
      end
      frame[FRAME_W-1-SEG_W*d -: SEG_W] = chars[idx[PW-1:0]];
    end
  end

endmodule

// File: rtl/panel_scroll_ctrl.sv
// Scroll sequencer for the 28-bit panel display register: periodically loads a
// sliding 4-character window of a latched message, stepping left or right.
module panel_scroll_ctrl
  import panel_pkg::*;
#(
  parameter int unsigned CHARS = 8,
  parameter int unsigned DIV_W = 24
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     dir,
  input  logic [SEG_W*CHARS-1:0]   msg,
  input  logic [$clog2(CHARS):0]   msg_len,
  input  logic [DIV_W-1:0]         period,
  output logic                     reg_load,
  output logic [1:0]               reg_s,
  output logic                     reg_m_sig,
  output logic [FRAME_W-1:0]       reg_d,
  output logic                     busy,
  output logic                     wrap
);

  localparam int unsigned PW = $clog2(CHARS);
  localparam int unsigned LW = PW + 1;

  state_t                 state, state_nx;
  logic [PW-1:0]          pos, pos_nx, pos_adv;
  logic [LW-1:0]          pos_inc;
  logic [DIV_W-1:0]       cnt, cnt_nx, per, per_nx;
  logic [LW-1:0]          len, len_nx;
  logic [SEG_W*CHARS-1:0] msg_q, msg_nx;
  logic [FRAME_W-1:0]     frame_nx;

  assign reg_s     = S_HOLD;
  assign reg_m_sig = 1'b0;

  always_comb begin
    pos_inc = LW'(pos) + LW'(1);
    if (dir) pos_adv = (pos == '0) ? PW'(len - LW'(1)) : pos - PW'(1);
    else     pos_adv = (pos_inc == len) ? '0 : pos_inc[PW-1:0];
  end

  always_comb begin
    state_nx = state;
    pos_nx   = pos;
    cnt_nx   = cnt;
    per_nx   = per;
    len_nx   = len;
    msg_nx   = msg_q;
    unique case (state)
      IDLE: begin
        if (start && !stop && msg_len != '0) begin
          msg_nx   = msg;
          len_nx   = (msg_len > LW'(CHARS)) ? LW'(CHARS) : msg_len;
          per_nx   = (period == '0) ? DIV_W'(1) : period;
          pos_nx   = '0;
          cnt_nx   = '0;
          state_nx = LOAD;
        end
      end
      LOAD: begin
        if (per == DIV_W'(1)) begin
          pos_nx   = pos_adv;
          state_nx = LOAD;
        end else begin
          cnt_nx   = DIV_W'(1);
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (cnt == per - DIV_W'(1)) begin
          pos_nx   = pos_adv;
          cnt_nx   = '0;
          state_nx = LOAD;
        end else begin
          cnt_nx = cnt + DIV_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    if (stop && state != IDLE) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end
  end

  panel_frame_mux #(.CHARS(CHARS)) u_frame_mux (
    .msg   (msg_nx),
    .len   (len_nx),
    .pos   (pos_nx),
    .frame (frame_nx)
  );

  // Outputs are registered from the next-state view so the load strobe and
  // its frame appear in the same cycle the state enters LOAD.
  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= IDLE;
      pos      <= '0;
      cnt      <= '0;
      per      <= '0;
      len      <= '0;
      msg_q    <= '0;
      reg_load <= 1'b0;
      reg_d    <= '0;
      busy     <= 1'b0;
      wrap     <= 1'b0;
    end else begin
      state    <= state_nx;
      pos      <= pos_nx;
      cnt      <= cnt_nx;
      per      <= per_nx;
      len      <= len_nx;
      msg_q    <= msg_nx;
      reg_load <= (state_nx == LOAD);
      busy     <= (state_nx != IDLE);
      wrap     <= (state_nx == LOAD) && (state != IDLE) && (pos_nx == '0);
      if (state_nx == LOAD) reg_d <= frame_nx;
    end
  end

endmodule

// File: tb/tb_panel_scroll_ctrl.sv
// Self-checking bench for panel_scroll_ctrl: expected loads (frame, wrap, cycle)
// are queued at start and compared whenever the DUT strobes reg_load.
module tb_panel_scroll_ctrl;

  logic        clk = 1'b0;
  logic        clr, start, stop, dir;
  logic [55:0] msg;
  logic [3:0]  msg_len;
  logic [23:0] period;
  logic        reg_load, reg_m_sig, busy, wrap;
  logic [1:0]  reg_s;
  logic [27:0] reg_d;

  typedef struct {
    logic [27:0] d;
    logic        w;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  panel_scroll_ctrl #(.CHARS(8), .DIV_W(24)) dut (
    .clk       (clk),
    .clr       (clr),
    .start     (start),
    .stop      (stop),
    .dir       (dir),
    .msg       (msg),
    .msg_len   (msg_len),
    .period    (period),
    .reg_load  (reg_load),
    .reg_s     (reg_s),
    .reg_m_sig (reg_m_sig),
    .reg_d     (reg_d),
    .busy      (busy),
    .wrap      (wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_load"}, 32'(reg_load), 0);
    check({tag, "_wrap"}, 32'(wrap), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_d"}, 32'(reg_d), 0);
    check({tag, "_s"}, 32'(reg_s), 0);
    check({tag, "_m"}, 32'(reg_m_sig), 0);
  endtask

  function automatic logic [27:0] model_frame(logic [55:0] m, int L, int pos);
    logic [27:0] f;
    int idx;
    f = '0;
    for (int d = 0; d < 4; d++) begin
      idx = (pos + d) % L;
      f[27-7*d -: 7] = m[7*idx +: 7];
    end
    return f;
  endfunction

  function automatic int model_adv(int pos, bit d, int L);
    if (d) return (pos == 0) ? L - 1 : pos - 1;
    return (pos + 1) % L;
  endfunction

  function automatic logic [55:0] pack_msg(logic [6:0] c0, logic [6:0] c1, logic [6:0] c2,
                                            logic [6:0] c3, logic [6:0] c4, logic [6:0] c5,
                                            logic [6:0] c6, logic [6:0] c7);
    return {c7, c6, c5, c4, c3, c2, c1, c0};
  endfunction

  always @(negedge clk) begin
    if (reg_load) begin
      if (sbq.size() == 0) begin
        check("load_unexpected", 32'(reg_load), 0);
      end else begin
        mon_e = sbq.pop_front();
        check("frame", 32'(reg_d), 32'(mon_e.d));
        check("wrap", 32'(wrap), 32'(mon_e.w));
        check("load_cycle", cyc, mon_e.cyc);
      end
    end else if (wrap) begin
      check("wrap_stray", 32'(wrap), 0);
    end
  end

  task automatic run_scroll(input logic [55:0] m, input logic [3:0] mlen, input logic [23:0] per,
                            input bit d0, input int nloads, input int flip, input int restart_at,
                            input int stop_delay, input bit use_clr);
    int L, P, pos, seen, waited;
    bit pulsed;
    logic [27:0] last_d;
    exp_t e;
    L = (mlen > 8) ? 8 : int'(mlen);
    P = (per == 0) ? 1 : int'(per);
    @(negedge clk);
    msg = m; msg_len = mlen; period = per; dir = d0; start = 1'b1;
    pos = 0;
    last_d = '0;
    for (int k = 0; k < nloads; k++) begin
      e.d = model_frame(m, L, pos);
      e.w = (k > 0) && (pos == 0);
      e.cyc = cyc + 1 + k * P;
      sbq.push_back(e);
      last_d = e.d;
      pos = model_adv(pos, (k >= flip) ? !d0 : d0, L);
    end
    seen = 0; waited = 0; pulsed = 1'b0;
    while (seen < nloads && waited < (nloads + 2) * P + 10) begin
      @(negedge clk);
      waited++;
      start = 1'b0;
      msg = m;
      if (reg_load) begin
        seen++;
        if (seen == 1) check("busy_rise", 32'(busy), 1);
        if (seen - 1 == flip) dir = !d0;
      end
      if (seen == restart_at && !pulsed) begin
        start = 1'b1;
        msg = ~m;
        pulsed = 1'b1;
      end
    end
    start = 1'b0;
    msg = m;
    check("load_count", seen, nloads);
    repeat (stop_delay) @(negedge clk);
    if (use_clr) begin
      clr = 1'b1;
      @(negedge clk);
      check_reset_outputs("clr1");
      @(negedge clk);
      check_reset_outputs("clr2");
      clr = 1'b0;
    end else begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      check("busy_fall", 32'(busy), 0);
    end
    repeat (2 * P + 3) @(negedge clk);
    check("frame_kept", 32'(reg_d), use_clr ? 32'd0 : 32'(last_d));
    check("busy_idle", 32'(busy), 0);
    check("sb_empty", sbq.size(), 0);
    sbq.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    logic [55:0] m_seq, m_ab, m_abc;
    clr = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0;
    msg = '0; msg_len = '0; period = '0;
    m_seq = pack_msg(7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd8);
    m_ab  = pack_msg(7'h41, 7'h42, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f);
    m_abc = pack_msg(7'h10, 7'h11, 7'h12, 7'h7f, 7'h7f, 7'h7f, 7'h7f, 7'h7f);
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    clr = 1'b0;

    // left scroll through a full wrap, ignored restart mid-run, stop during LOAD
    run_scroll(m_seq, 4'd8, 24'd3, 1'b0, 10, 100, 3, 0, 1'b0);
    // right scroll with dir flipped after the third load, stop during HOLD
    run_scroll(m_seq, 4'd8, 24'd3, 1'b1, 5, 2, -1, 1, 1'b0);
    // two characters, period 0 treated as 1: load every cycle
    run_scroll(m_ab, 4'd2, 24'd0, 1'b0, 6, 100, -1, 0, 1'b0);
    // three characters, period 1, right scroll
    run_scroll(m_abc, 4'd3, 24'd1, 1'b1, 5, 100, -1, 0, 1'b0);
    // msg_len beyond CHARS clamps to 8
    run_scroll(m_seq, 4'd12, 24'd2, 1'b0, 9, 100, -1, 0, 1'b0);
    // clear while in HOLD
    run_scroll(m_seq, 4'd8, 24'd5, 1'b0, 1, 100, -1, 2, 1'b1);

    // start and stop together from IDLE
    @(negedge clk);
    msg = m_seq; msg_len = 4'd8; period = 24'd2; start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    check("startstop_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    check("startstop_idle", 32'(busy), 0);

    // zero-length message is ignored
    @(negedge clk);
    msg_len = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("len0_busy", 32'(busy), 0);
    repeat (4) @(negedge clk);
    check("len0_idle", 32'(busy), 0);
    check("len0_d", 32'(reg_d), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
